// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: register file, immediate/opcode decode, hazard detection
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] instr_pc,
    input  logic            instr_valid,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic [11:0]     operation,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] pc,
    output logic            isBranch
);

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;

    // ADDI x0,x0,0 encoded as {instr[30],instr[25],funct3,opcode}
    localparam logic [11:0] OP_BUBBLE  = 12'h013;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_idx;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;

    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    // Sign-extended immediates for every RV32I format
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Per-instruction class flags and immediate selection
    logic            writes_rd;
    logic            reads_rs1;
    logic            reads_rs2;
    logic            is_load;
    logic            is_branch_op;
    logic [XLEN-1:0] imm_dec;

    // Classify the opcode: which registers it touches and which immediate it carries
    always_comb begin
        writes_rd    = 1'b0;
        reads_rs1    = 1'b0;
        reads_rs2    = 1'b0;
        is_load      = 1'b0;
        is_branch_op = 1'b0;
        imm_dec      = '0;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                imm_dec   = imm_i;
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                is_load   = 1'b1;
                imm_dec   = imm_i;
            end
            OPC_JALR: begin
                writes_rd    = 1'b1;
                reads_rs1    = 1'b1;
                is_branch_op = 1'b1;
                imm_dec      = imm_i;
            end
            OPC_STORE: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                imm_dec   = imm_s;
            end
            OPC_BRANCH: begin
                reads_rs1    = 1'b1;
                reads_rs2    = 1'b1;
                is_branch_op = 1'b1;
                imm_dec      = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm_dec   = imm_u;
            end
            OPC_JAL: begin
                writes_rd    = 1'b1;
                is_branch_op = 1'b1;
                imm_dec      = imm_j;
            end
            default: begin
            end
        endcase
    end

    // Register file; entry 0 is never written and reads are masked to 0
    logic [XLEN-1:0] regs [0:31];

    // Writeback port: clear everything on reset, ignore writes to x0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand reads with write-through so a same-cycle writeback is seen (distance-2 bypass)
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Read both sources; unread operands are presented as 0
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (reads_rs1 && (rs1_idx != 5'd0)) begin
            rs1_val = (wb_en && (wb_rd == rs1_idx)) ? wb_data : regs[rs1_idx];
        end
        if (reads_rs2 && (rs2_idx != 5'd0)) begin
            rs2_val = (wb_en && (wb_rd == rs2_idx)) ? wb_data : regs[rs2_idx];
        end
    end

    // State describing the instruction currently in execute (the last one issued)
    logic [4:0] last_rd;
    logic       last_writes;
    logic       last_load;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic issue_bubble;

    // Distance-1 dependences: a read source matching the destination now in execute
    assign rs1_hit = reads_rs1 && (rs1_idx != 5'd0) && (rs1_idx == last_rd) && last_writes;
    assign rs2_hit = reads_rs2 && (rs2_idx != 5'd0) && (rs2_idx == last_rd) && last_writes;

    // A load result is not available from execute, so the consumer must wait one cycle
    assign load_use = instr_valid && last_load && (rs1_hit || rs2_hit);

    // Flush discards the held instruction, so it must never ask fetch to hold
    assign stall = load_use && !flush;

    assign issue_bubble = flush || !instr_valid || load_use;

    // Issue register: either the decoded instruction or a bubble, plus hazard state for next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operation   <= OP_BUBBLE;
            rs1         <= '0;
            rs2         <= '0;
            imm         <= '0;
            rd          <= 5'd0;
            rs1_fwd     <= 1'b0;
            rs2_fwd     <= 1'b0;
            pc          <= '0;
            isBranch    <= 1'b0;
            last_rd     <= 5'd0;
            last_writes <= 1'b0;
            last_load   <= 1'b0;
        end else if (issue_bubble) begin
            operation   <= OP_BUBBLE;
            rs1         <= '0;
            rs2         <= '0;
            imm         <= '0;
            rd          <= 5'd0;
            rs1_fwd     <= 1'b0;
            rs2_fwd     <= 1'b0;
            pc          <= '0;
            isBranch    <= 1'b0;
            last_rd     <= 5'd0;
            last_writes <= 1'b0;
            last_load   <= 1'b0;
        end else begin
            operation   <= {instr[30], instr[25], funct3, opcode};
            rs1         <= rs1_val;
            rs2         <= rs2_val;
            imm         <= imm_dec;
            rd          <= writes_rd ? rd_idx : 5'd0;
            rs1_fwd     <= rs1_hit && !last_load;
            rs2_fwd     <= rs2_hit && !last_load;
            pc          <= instr_pc;
            isBranch    <= is_branch_op;
            last_rd     <= writes_rd ? rd_idx : 5'd0;
            last_writes <= writes_rd;
            last_load   <= is_load;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with directed and random stimulus
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [11:0] operation;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] pc;
    logic        isBranch;

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .operation(operation), .rs1(rs1), .rs2(rs2),
        .imm(imm), .rd(rd), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .pc(pc), .isBranch(isBranch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr = 32'h0; instr_pc = 32'h0; instr_valid = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rf [0:31];
    logic [4:0]  m_last_rd;
    logic        m_last_wr;
    logic        m_last_ld;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    // kind: 0 other, 1 R, 2 I-alu, 3 load, 4 jalr, 5 store, 6 branch, 7 U, 8 jal
    function automatic int kind_of(input logic [31:0] ins);
        case (ins & 32'h7F)
            32'h33: return 1;
            32'h13: return 2;
            32'h03: return 3;
            32'h67: return 4;
            32'h23: return 5;
            32'h63: return 6;
            32'h37, 32'h17: return 7;
            32'h6F: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int k;
        k = kind_of(ins);
        if (k == 2 || k == 3 || k == 4) return sext(ins >> 20, 12);
        if (k == 5) return sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
        if (k == 6) return sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                                (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
        if (k == 7) return ins & 32'hFFFFF000;
        if (k == 8) return sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                                (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx == 0) return 32'h0;
        if (wb_en && (int'(wb_rd) == idx)) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_last_rd = 5'd0; m_last_wr = 1'b0; m_last_ld = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        total++;
        if (operation !== 12'h013 || rd !== 5'd0 || rs1 !== 32'h0 || pc !== 32'h0 || isBranch !== 1'b0) begin
            bad++;
            $display("FAIL reset_bubble: op=%h rd=%0d rs1=%h pc=%h br=%b, need op=013 rd=0 rs1=0 pc=0 br=0",
                     operation, rd, rs1, pc, isBranch);
        end
        reset = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
        tick();
        idle_inputs();
        instr = 32'h0002_8333; instr_pc = 32'h40; instr_valid = 1'b1;
        tick();
        total++;
        if (rs1 !== 32'h1234_5678 || rd !== 5'd6 || pc !== 32'h40) begin
            bad++;
            $display("FAIL reset_pre_read: rs1=%h rd=%0d pc=%h, need rs1=12345678 rd=6 pc=40", rs1, rd, pc);
        end
        // asynchronous reset mid-cycle: outputs collapse without a clock edge
        #2 reset = 1'b0;
        #1;
        total++;
        if (operation !== 12'h013 || rd !== 5'd0 || rs1 !== 32'h0 || pc !== 32'h0 ||
            rs1_fwd !== 1'b0 || rs2_fwd !== 1'b0 || imm !== 32'h0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: op=%h rd=%0d rs1=%h pc=%h imm=%h stall=%b, need bubble",
                     operation, rd, rs1, pc, imm, stall);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (rs1 !== 32'h0 || rd !== 5'd6) begin
            bad++;
            $display("FAIL reset_rf_cleared: rs1=%h rd=%0d, need rs1=0 rd=6", rs1, rd);
        end
    endtask

    task automatic test_write_through();
        idle_inputs();
        tick();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        instr = 32'h0002_8333; instr_pc = 32'h80; instr_valid = 1'b1;
        tick();
        total++;
        if (rs1 !== 32'hDEAD_BEEF || rs1_fwd !== 1'b0 || operation !== 12'h033) begin
            bad++;
            $display("FAIL write_through: rs1=%h fwd=%b op=%h, need rs1=deadbeef fwd=0 op=033",
                     rs1, rs1_fwd, operation);
        end
        wb_en = 1'b0;
        tick();
        total++;
        if (rs1 !== 32'hDEAD_BEEF || rs1_fwd !== 1'b0) begin
            bad++;
            $display("FAIL rf_retained: rs1=%h fwd=%b, need rs1=deadbeef fwd=0", rs1, rs1_fwd);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        instr = 32'h0050_0093; instr_pc = 32'h100; instr_valid = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL fwd_no_stall: stall=%b need 0", stall);
        end
        tick();
        total++;
        if (imm !== 32'h5 || rd !== 5'd1 || operation !== 12'h013 || rs1_fwd !== 1'b0) begin
            bad++;
            $display("FAIL addi_issue: imm=%h rd=%0d op=%h fwd=%b, need imm=5 rd=1 op=013 fwd=0",
                     imm, rd, operation, rs1_fwd);
        end
        instr = 32'h0010_8133; instr_pc = 32'h104;
        tick();
        total++;
        if (rs1_fwd !== 1'b1 || rs2_fwd !== 1'b1 || operation !== 12'h033 || rd !== 5'd2 || pc !== 32'h104) begin
            bad++;
            $display("FAIL fwd_both: f1=%b f2=%b op=%h rd=%0d pc=%h, need 1 1 033 2 104",
                     rs1_fwd, rs2_fwd, operation, rd, pc);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        instr = 32'h0002_2183; instr_pc = 32'h200; instr_valid = 1'b1;
        tick();
        total++;
        if (rd !== 5'd3 || operation !== 12'h103) begin
            bad++;
            $display("FAIL lw_issue: rd=%0d op=%h, need rd=3 op=103", rd, operation);
        end
        instr = 32'h0001_83B3; instr_pc = 32'h204;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall: stall=%b need 1", stall);
        end
        tick();
        total++;
        if (operation !== 12'h013 || rd !== 5'd0 || pc !== 32'h0) begin
            bad++;
            $display("FAIL lu_bubble: op=%h rd=%0d pc=%h, need 013 0 0", operation, rd, pc);
        end
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE_0001;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL lu_release: stall=%b need 0", stall);
        end
        tick();
        total++;
        if (rs1 !== 32'hCAFE_0001 || rs1_fwd !== 1'b0 || rd !== 5'd7 || pc !== 32'h204) begin
            bad++;
            $display("FAIL lu_consumer: rs1=%h fwd=%b rd=%0d pc=%h, need cafe0001 0 7 204",
                     rs1, rs1_fwd, rd, pc);
        end
    endtask

    task automatic test_branch_imm();
        idle_inputs();
        instr = 32'hFE00_0CE3; instr_pc = 32'h300; instr_valid = 1'b1;
        tick();
        total++;
        if (imm !== 32'hFFFF_FFF8 || isBranch !== 1'b1 || rd !== 5'd0 || operation !== 12'hC63 || pc !== 32'h300) begin
            bad++;
            $display("FAIL beq_decode: imm=%h br=%b rd=%0d op=%h pc=%h, need fffffff8 1 0 c63 300",
                     imm, isBranch, rd, operation, pc);
        end
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        instr = 32'h0002_2183; instr_pc = 32'h400; instr_valid = 1'b1;
        tick();
        instr = 32'h0001_83B3; instr_pc = 32'h404; flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: stall=%b need 0", stall);
        end
        tick();
        total++;
        if (operation !== 12'h013 || rd !== 5'd0 || pc !== 32'h0) begin
            bad++;
            $display("FAIL flush_bubble: op=%h rd=%0d pc=%h, need 013 0 0", operation, rd, pc);
        end
        flush = 1'b0;
        instr = 32'h0001_8433; instr_pc = 32'h500;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_fresh_stall: stall=%b need 0", stall);
        end
        tick();
        total++;
        if (rd !== 5'd8 || rs1_fwd !== 1'b0 || pc !== 32'h500) begin
            bad++;
            $display("FAIL flush_fresh: rd=%0d fwd=%b pc=%h, need 8 0 500", rd, rs1_fwd, pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] opcodes [9];
        logic        m_stall;
        logic        lu;
        logic        bubble;
        logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
        logic [11:0] e_op;
        logic [4:0]  e_rd;
        logic        e_f1, e_f2, e_br;
        int          k, s1, s2, d;
        logic        rd1, rd2, wr, ld;
        opcodes = '{32'h33, 32'h13, 32'h03, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F};
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
        m_stall = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!m_stall) begin
                instr = $urandom;
                instr = (instr & 32'hFE0F_8000) | opcodes[$urandom_range(0, 8)];
                instr = instr | (32'($urandom_range(0, 7)) << 7) | (32'($urandom_range(0, 7)) << 15)
                              | (32'($urandom_range(0, 7)) << 20);
                instr_pc = $urandom;
                instr_valid = ($urandom_range(0, 7) != 0);
            end
            flush = ($urandom_range(0, 7) == 0);
            wb_en = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;

            k   = kind_of(instr);
            s1  = int'(instr[19:15]);
            s2  = int'(instr[24:20]);
            d   = int'(instr[11:7]);
            rd1 = (k == 1 || k == 2 || k == 3 || k == 4 || k == 5 || k == 6);
            rd2 = (k == 1 || k == 5 || k == 6);
            wr  = (k == 1 || k == 2 || k == 3 || k == 4 || k == 7 || k == 8);
            ld  = (k == 3);
            lu  = instr_valid && m_last_ld && m_last_rd != 0 &&
                  ((rd1 && s1 == int'(m_last_rd)) || (rd2 && s2 == int'(m_last_rd)));
            m_stall = lu && !flush;
            bubble  = flush || !instr_valid || lu;
            if (bubble) begin
                e_op = 12'h013; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_rd = 0;
                e_f1 = 0; e_f2 = 0; e_pc = 0; e_br = 0;
            end else begin
                e_op  = {instr[30], instr[25], instr[14:12], instr[6:0]};
                e_rs1 = rd1 ? model_read(s1) : 32'h0;
                e_rs2 = rd2 ? model_read(s2) : 32'h0;
                e_imm = model_imm(instr);
                e_rd  = wr ? 5'(d) : 5'd0;
                e_f1  = rd1 && s1 != 0 && s1 == int'(m_last_rd) && m_last_wr && !m_last_ld;
                e_f2  = rd2 && s2 != 0 && s2 == int'(m_last_rd) && m_last_wr && !m_last_ld;
                e_pc  = instr_pc;
                e_br  = (k == 4 || k == 6 || k == 8);
            end

            #1;
            total++;
            if (stall !== m_stall) begin
                bad++;
                $display("FAIL rand_stall[%0d]: stall=%b need %b instr=%h", n, stall, m_stall, instr);
            end
            tick();
            if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
            if (bubble) begin
                m_last_rd = 0; m_last_wr = 0; m_last_ld = 0;
            end else begin
                m_last_rd = wr ? 5'(d) : 5'd0; m_last_wr = wr; m_last_ld = ld;
            end
            total++;
            if (operation !== e_op || rs1 !== e_rs1 || rs2 !== e_rs2 || imm !== e_imm || rd !== e_rd ||
                rs1_fwd !== e_f1 || rs2_fwd !== e_f2 || pc !== e_pc || isBranch !== e_br) begin
                bad++;
                $display("FAIL rand_issue[%0d]: got op=%h rs1=%h rs2=%h imm=%h rd=%0d f=%b%b pc=%h br=%b need op=%h rs1=%h rs2=%h imm=%h rd=%0d f=%b%b pc=%h br=%b",
                         n, operation, rs1, rs2, imm, rd, rs1_fwd, rs2_fwd, pc, isBranch,
                         e_op, e_rs1, e_rs2, e_imm, e_rd, e_f1, e_f2, e_pc, e_br);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_forward();
        test_load_use();
        test_branch_imm();
        test_flush_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
